// File: rtl/adc_channel_scanner.sv
// rtl/adc_channel_scanner.sv - round-robin MAX10 ADC scanner with per-slot averaging, mV scaling and LED bar
//
// Ports:
//   Clk, Reset_h             clock, synchronous active-high reset
//   cmd_valid/cmd_channel    ADC command stream (held until cmd_ready)
//   cmd_ready                ADC command accepted
//   rsp_valid/rsp_channel/rsp_data  ADC response stream
//   sel_ch                   slot shown on mv_out/raw_out/leds
//   mv_out, raw_out          registered millivolt / averaged raw code of slot sel_ch
//   res_valid, res_slot      one-cycle pulse naming the slot whose result is being stored
//   leds                     LED display of slot sel_ch
//   err_mismatch, err_timeout  sticky error flags, cleared only by reset
//
// Build option: define ADC_BARGRAPH_EN to drive leds as a thermometer bar
// graph; otherwise leds shows the upper LED_W bits of the millivolt value.
module adc_channel_scanner #(
    parameter int NUM_CH      = 2,
    parameter int CH_BASE     = 1,
    parameter int AVG_LOG2    = 2,
    parameter int VREF_MV     = 5000,
    parameter int TIMEOUT_CYC = 1024,
    parameter int LED_W       = 10
) (
    input  logic             Clk,
    input  logic             Reset_h,
    output logic             cmd_valid,
    output logic [4:0]       cmd_channel,
    input  logic             cmd_ready,
    input  logic             rsp_valid,
    input  logic [4:0]       rsp_channel,
    input  logic [11:0]      rsp_data,
    input  logic [2:0]       sel_ch,
    output logic [12:0]      mv_out,
    output logic [11:0]      raw_out,
    output logic             res_valid,
    output logic [2:0]       res_slot,
    output logic [LED_W-1:0] leds,
    output logic             err_mismatch,
    output logic             err_timeout
);

    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [2:0]       LAST_SLOT = 3'(NUM_CH - 1);
    localparam logic [TMR_W-1:0] LAST_TMR  = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        STORE = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       slot;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [TMR_W-1:0] tmr;

    // Sized for the maximum 8 slots; entries at or above NUM_CH stay zero.
    logic [11:0] raw_bank [0:7];
    logic [12:0] mv_bank  [0:7];

    logic [11:0] avg;
    logic [24:0] prod;
    logic [24:0] quo;
    logic [12:0] mv_new;
    logic        rsp_match;

    // Command channel is decoded straight from the slot register.
    assign cmd_channel = 5'(CH_BASE) + {2'b00, slot};
    assign rsp_match   = (rsp_channel == cmd_channel);

    assign avg    = 12'(acc >> AVG_LOG2);
    assign prod   = 25'(avg) * 25'(VREF_MV);
    assign quo    = prod / 25'd4095;
    assign mv_new = (quo > 25'd8191) ? 13'h1FFF : quo[12:0];

`ifdef ADC_BARGRAPH_EN
    function automatic logic [LED_W-1:0] led_map(input logic [12:0] mv);
        logic [LED_W-1:0] r;
        logic [31:0]      n;
        r = '0;
        n = (32'(mv) * 32'(LED_W)) / 32'(VREF_MV);
        if (n > 32'(LED_W)) n = 32'(LED_W);
        for (int i = 0; i < LED_W; i++) r[i] = (32'(i) < n);
        return r;
    endfunction
`else
    function automatic logic [LED_W-1:0] led_map(input logic [12:0] mv);
        return LED_W'(mv >> (13 - LED_W));
    endfunction
`endif

    // Sequencer: one outstanding command at a time. cmd_valid is forced low
    // for the first cycle after reset and raised on every entry into ISSUE.
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            state        <= ISSUE;
            slot         <= '0;
            acc          <= '0;
            cnt          <= '0;
            tmr          <= '0;
            cmd_valid    <= 1'b0;
            res_valid    <= 1'b0;
            res_slot     <= '0;
            err_mismatch <= 1'b0;
            err_timeout  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                raw_bank[i] <= '0;
                mv_bank[i]  <= '0;
            end
        end else begin
            res_valid <= 1'b0;
            case (state)
                ISSUE: begin
                    if (!cmd_valid) begin
                        cmd_valid <= 1'b1;
                    end else if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        tmr       <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    // A response wins over a timeout on the same cycle.
                    if (rsp_valid) begin
                        if (rsp_match) begin
                            acc <= acc + ACC_W'(rsp_data);
                            cnt <= cnt + CNT_W'(1);
                            if (cnt == LAST_CNT) begin
                                state     <= STORE;
                                res_valid <= 1'b1;
                                res_slot  <= slot;
                            end else begin
                                state     <= ISSUE;
                                cmd_valid <= 1'b1;
                            end
                        end else begin
                            err_mismatch <= 1'b1;
                            state        <= ISSUE;
                            cmd_valid    <= 1'b1;
                        end
                    end else if (tmr == LAST_TMR) begin
                        err_timeout <= 1'b1;
                        state       <= ISSUE;
                        cmd_valid   <= 1'b1;
                    end else begin
                        tmr <= tmr + TMR_W'(1);
                    end
                end
                STORE: begin
                    raw_bank[slot] <= avg;
                    mv_bank[slot]  <= mv_new;
                    acc            <= '0;
                    cnt            <= '0;
                    slot           <= (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;
                    state          <= ISSUE;
                    cmd_valid      <= 1'b1;
                end
                default: begin
                    state     <= ISSUE;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

    // Display stage: one register after the bank or a sel_ch change.
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            mv_out  <= '0;
            raw_out <= '0;
            leds    <= '0;
        end else if ({29'b0, sel_ch} < 32'(NUM_CH)) begin
            mv_out  <= mv_bank[sel_ch];
            raw_out <= raw_bank[sel_ch];
            leds    <= led_map(mv_bank[sel_ch]);
        end else begin
            mv_out  <= '0;
            raw_out <= '0;
            leds    <= '0;
        end
    end

endmodule

// File: doc/adc_channel_scanner.md
Name: adc_channel_scanner

Overview:
- Round-robin sequencer for the MAX10 modular ADC command/response streams across NUM_CH consecutive channels.
- Per channel: averages 2^AVG_LOG2 samples, scales the result to millivolts and holds it in a register bank.
- Drives the LED bar graph for one selected channel; sits between final_soc ADC ports and board LEDR.

Parameters:
NUM_CH, 2, number of scanned channels (1..8)
CH_BASE, 1, ADC channel number of scan slot 0; slot i uses channel CH_BASE+i
AVG_LOG2, 2, log2 of samples averaged per result (0..6)
VREF_MV, 5000, millivolts represented by full-scale code 4095
TIMEOUT_CYC, 1024, cycles to wait for a response before retry
LED_W, 10, LED output width

Ports:
Clk  in  1  system clock (50 MHz)
Reset_h  in  1  synchronous active-high reset
cmd_valid  out  1  ADC command valid
cmd_channel  out  5  ADC command channel
cmd_ready  in  1  ADC command accepted
rsp_valid  in  1  ADC response valid
rsp_channel  in  5  ADC response channel
rsp_data  in  12  ADC response sample
sel_ch  in  3  scan slot shown on leds/mv_out
mv_out  out  13  millivolts of slot sel_ch
raw_out  out  12  averaged raw code of slot sel_ch
res_valid  out  1  one-cycle pulse: a slot result was updated
res_slot  out  3  slot updated with res_valid
leds  out  LED_W  bar graph of slot sel_ch
err_mismatch  out  1  sticky: response channel did not match the command
err_timeout  out  1  sticky: response timeout occurred

Behaviour:
- Reset (any state, mid-accumulation included): FSM to ISSUE, slot=0, accumulator=0, sample count=0, all bank entries 0, cmd_valid=0 for that cycle, res_valid=0, errors cleared, leds=0.
- States:
  - ISSUE: cmd_valid=1, cmd_channel=CH_BASE+slot; hold both until cmd_ready; the handshake cycle goes to WAIT. Only one command is outstanding.
  - WAIT: count cycles.
    - rsp_valid with rsp_channel==expected: acc += rsp_data (width 12+AVG_LOG2), count++, go to ISSUE; on the 2^AVG_LOG2-th sample go to STORE instead.
    - rsp_valid with any other channel: discard, set err_mismatch, go to ISSUE for the same slot; acc and count unchanged.
    - Counter reaching TIMEOUT_CYC: set err_timeout, go to ISSUE for the same slot.
    - rsp_valid on the timeout cycle counts as a response, not a timeout.
    - rsp_valid outside WAIT is ignored.
  - STORE (1 cycle):
    - avg = acc >> AVG_LOG2.
    - mv = (avg*VREF_MV)/4095, integer truncation, 25-bit intermediate, saturated to 8191.
    - Write raw and mv to bank[slot]; pulse res_valid with res_slot=slot.
    - Clear acc and count; slot = (slot==NUM_CH-1) ? 0 : slot+1; go to ISSUE.
- Latency: res_valid occurs 1 cycle after the last accepted response. mv_out, raw_out and leds are registered from bank[sel_ch] and update the cycle after the bank write or a sel_ch change.
- sel_ch >= NUM_CH: mv_out=0, raw_out=0, leds=0.

Optional Feature:
- Macro ADC_BARGRAPH_EN.
- Defined: leds is a thermometer code; n = (mv*LED_W)/VREF_MV, clamped to LED_W; leds[n-1:0]=1, the rest 0.
- Undefined: leds = mv[12:13-LED_W] (binary bits), matching the legacy LEDR display.

Test Plan:
- Defaults; cmd_ready always 1; respond 3 cycles after each command with data = 4095 on the correct channel. Required: cmd_channel sequence 1,1,1,1,2,...; slot 0 res_valid after the 4th response; sel_ch=0 gives mv_out=5000, raw_out=4095.
- Samples 2000,2100,2000,2100 on ch1. Required: raw_out=2050, mv_out=2503.
- Response with rsp_channel=7 during WAIT. Required: err_mismatch=1; sample dropped; next cmd_channel = same channel; count unchanged.
- TIMEOUT_CYC=16, no response. Required: err_timeout=1 at cycle 16 of WAIT; command re-issued for the same slot.
- mv=2500. With ADC_BARGRAPH_EN: leds=0x01F. Without: leds=0x138.
- Reset_h after 2 of 4 samples. Required: outputs zeroed; the next 4 samples of 1000 give raw_out=1000, mv_out=1221 (partial accumulation discarded).
